// File: rtl/uart_defines_pkg.sv
// Shared UART transmit definitions: LCR bit indices, serializer state encodings,
// FIFO depth default and stop-bit tick counts.
package uart_defines_pkg;

    localparam int TF_DEPTH_DEFAULT   = 16;
    localparam int TF_COUNT_W_DEFAULT = 5;

    localparam int UART_LC_SB = 2;
    localparam int UART_LC_PE = 3;
    localparam int UART_LC_EP = 4;
    localparam int UART_LC_SP = 5;
    localparam int UART_LC_BC = 6;

    localparam int STOP_TICKS_1  = 16;
    localparam int STOP_TICKS_15 = 24;
    localparam int STOP_TICKS_2  = 32;

    typedef enum logic [2:0] {
        s_idle   = 3'd0,
        s_start  = 3'd1,
        s_data   = 3'd2,
        s_parity = 3'd3,
        s_stop   = 3'd4
    } tx_state_t;

    // Down-counter preload for the stop phase (ticks minus one)
    function automatic logic [4:0] stop_load(input logic [7:0] lcr);
        if (!lcr[UART_LC_SB])
            return 5'(STOP_TICKS_1 - 1);
        else if (lcr[1:0] == 2'b00)
            return 5'(STOP_TICKS_15 - 1);
        else
            return 5'(STOP_TICKS_2 - 1);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO: 8-bit entries, push/pop/flush, occupancy count.
// Pushes into a full FIFO are dropped unless a pop occurs on the same clock.
module uart_tx_fifo
    import uart_defines_pkg::*;
#(
    parameter int DEPTH   = TF_DEPTH_DEFAULT,
    parameter int COUNT_W = TF_COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               wb_rst_i,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && !flush && ((count != COUNT_W'(DEPTH)) || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: TX FIFO plus start/data/parity/stop serializer paced by a 16x tick.
// Build option UART_TX_BREAK_EN enables lcr[6] break forcing on stx_pad_o.
module uart_tx_engine
    import uart_defines_pkg::*;
#(
    parameter int TF_DEPTH   = TF_DEPTH_DEFAULT,
    parameter int TF_COUNT_W = TF_COUNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  wb_rst_i,
    input  logic                  enable,
    input  logic [7:0]            lcr,
    input  logic                  tf_push,
    input  logic [7:0]            wb_dat_i,
    input  logic                  tx_reset,
    output logic                  stx_pad_o,
    output logic [TF_COUNT_W-1:0] tf_count,
    output logic                  thre,
    output logic                  temt,
    output logic [2:0]            tstate
);

    tx_state_t  state;
    logic [4:0] cnt16;
    logic [2:0] bitcnt;
    logic [7:0] shift;
    logic [7:0] tx_data;
    logic       stx_r;
    logic       tf_pop;
    logic [7:0] fifo_dout;
    logic [7:0] data_mask;
    logic       parity_bit;

    uart_tx_fifo #(
        .DEPTH   (TF_DEPTH),
        .COUNT_W (TF_COUNT_W)
    ) u_fifo (
        .clk      (clk),
        .wb_rst_i (wb_rst_i),
        .push     (tf_push),
        .pop      (tf_pop),
        .flush    (tx_reset),
        .din      (wb_dat_i),
        .dout     (fifo_dout),
        .count    (tf_count)
    );

    always_comb begin
        case (lcr[1:0])
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
    end

    assign parity_bit = lcr[UART_LC_SP] ? ~lcr[UART_LC_EP]
                      : (lcr[UART_LC_EP] ? ^(tx_data & data_mask) : ~^(tx_data & data_mask));

    // The stop phase's last tick pops directly so back-to-back frames have no idle gap
    assign tf_pop = enable && (tf_count != '0) &&
                    ((state == s_idle) || ((state == s_stop) && (cnt16 == 5'd0)));

    always_ff @(posedge clk or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= s_idle;
            cnt16   <= 5'd0;
            bitcnt  <= 3'd0;
            shift   <= 8'h00;
            tx_data <= 8'h00;
            stx_r   <= 1'b1;
        end else if (enable) begin
            case (state)
                s_idle: begin
                    stx_r <= 1'b1;
                    if (tf_pop) begin
                        shift   <= fifo_dout;
                        tx_data <= fifo_dout;
                        cnt16   <= 5'd15;
                        stx_r   <= 1'b0;
                        state   <= s_start;
                    end
                end
                s_start: begin
                    if (cnt16 == 5'd0) begin
                        state  <= s_data;
                        stx_r  <= shift[0];
                        cnt16  <= 5'd15;
                        bitcnt <= 3'd4 + {1'b0, lcr[1:0]};
                    end else begin
                        cnt16 <= cnt16 - 1'b1;
                    end
                end
                s_data: begin
                    if (cnt16 == 5'd0) begin
                        cnt16 <= 5'd15;
                        if (bitcnt == 3'd0) begin
                            if (lcr[UART_LC_PE]) begin
                                state <= s_parity;
                                stx_r <= parity_bit;
                            end else begin
                                state <= s_stop;
                                stx_r <= 1'b1;
                                cnt16 <= stop_load(lcr);
                            end
                        end else begin
                            shift  <= {1'b0, shift[7:1]};
                            stx_r  <= shift[1];
                            bitcnt <= bitcnt - 1'b1;
                        end
                    end else begin
                        cnt16 <= cnt16 - 1'b1;
                    end
                end
                s_parity: begin
                    if (cnt16 == 5'd0) begin
                        state <= s_stop;
                        stx_r <= 1'b1;
                        cnt16 <= stop_load(lcr);
                    end else begin
                        cnt16 <= cnt16 - 1'b1;
                    end
                end
                s_stop: begin
                    if (cnt16 == 5'd0) begin
                        if (tf_pop) begin
                            shift   <= fifo_dout;
                            tx_data <= fifo_dout;
                            cnt16   <= 5'd15;
                            stx_r   <= 1'b0;
                            state   <= s_start;
                        end else begin
                            state <= s_idle;
                            stx_r <= 1'b1;
                        end
                    end else begin
                        cnt16 <= cnt16 - 1'b1;
                    end
                end
                default: begin
                    state <= s_idle;
                    stx_r <= 1'b1;
                end
            endcase
        end
    end

    assign thre   = (tf_count == '0);
    assign temt   = thre && (state == s_idle);
    assign tstate = state;

`ifdef UART_TX_BREAK_EN
    assign stx_pad_o = stx_r & ~lcr[UART_LC_BC];
`else
    assign stx_pad_o = stx_r;
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames are queued at stimulus time,
// a monitor captures each frame on stx_pad_o and compares it sample by sample.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       wb_rst_i;
    logic       enable;
    logic [7:0] lcr;
    logic       tf_push;
    logic [7:0] wb_dat_i;
    logic       tx_reset;
    logic       stx_pad_o;
    logic [4:0] tf_count;
    logic       thre;
    logic       temt;
    logic [2:0] tstate;

    uart_tx_engine dut (
        .clk       (clk),
        .wb_rst_i  (wb_rst_i),
        .enable    (enable),
        .lcr       (lcr),
        .tf_push   (tf_push),
        .wb_dat_i  (wb_dat_i),
        .tx_reset  (tx_reset),
        .stx_pad_o (stx_pad_o),
        .tf_count  (tf_count),
        .thre      (thre),
        .temt      (temt),
        .tstate    (tstate)
    );

    always #5 clk = ~clk;

    // mode: 0 = no follow-up check, 1 = next frame must start immediately, 2 = line idles and temt rises
    typedef struct {
        logic [7:0] data;
        int         nbits;
        bit         par_en;
        bit         par;
        int         stop;
        int         mode;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b1;
    bit   in_frame = 1'b0;
    int   post_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic expect_frame(input logic [7:0] d, input int nb, input bit pe, input bit p,
                                input int st, input int mode);
        exp_t e;
        e.data = d; e.nbits = nb; e.par_en = pe; e.par = p; e.stop = st; e.mode = mode;
        exp_q.push_back(e);
    endtask

    task automatic push_byte(input logic [7:0] d);
        @(negedge clk);
        tf_push  = 1'b1;
        wb_dat_i = d;
        @(negedge clk);
        tf_push  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        bit ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !in_frame && temt) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] lcrv, input logic [7:0] d, input int nb,
                        input bit pe, input bit p, input int st);
        lcr = lcrv;
        expect_frame(d, nb, pe, p, st, 2);
        push_byte(d);
        wait_done($sformatf("done_lcr%02h_d%02h", lcrv, d), 400);
    endtask

    // Monitor
    initial begin : monitor
        exp_t e;
        logic expv [256];
        logic obs  [256];
        int   t;
        int   bad;
        forever begin
            @(negedge clk);
            if (post_mode == 1) begin
                check("b2b_no_gap", {31'd0, stx_pad_o}, 32'd0);
            end else if (post_mode == 2) begin
                check("temt_after_frame", {31'd0, temt}, 32'd1);
                check("line_idle_after_frame", {31'd0, stx_pad_o}, 32'd1);
            end
            post_mode = 0;
            if (mon_en && stx_pad_o === 1'b0) begin
                in_frame = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {31'd0, stx_pad_o}, 32'd1);
                    while (stx_pad_o === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    t = 0;
                    for (int i = 0; i < 16; i++) expv[t++] = 1'b0;
                    for (int b = 0; b < e.nbits; b++)
                        for (int i = 0; i < 16; i++) expv[t++] = e.data[b];
                    if (e.par_en)
                        for (int i = 0; i < 16; i++) expv[t++] = e.par;
                    for (int i = 0; i < e.stop; i++) expv[t++] = 1'b1;
                    obs[0] = stx_pad_o;
                    for (int i = 1; i < t; i++) begin
                        @(negedge clk);
                        obs[i] = stx_pad_o;
                    end
                    bad = -1;
                    for (int i = 0; i < t; i++)
                        if (bad < 0 && obs[i] !== expv[i]) bad = i;
                    n_tests++;
                    if (bad >= 0) begin
                        n_fail++;
                        $display("FAIL frame_%02h: sample %0d got %b want %b",
                                 e.data, bad, obs[bad], expv[bad]);
                    end
                    post_mode = e.mode;
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        wb_rst_i = 1'b1;
        enable   = 1'b1;
        lcr      = 8'h03;
        tf_push  = 1'b0;
        wb_dat_i = 8'h00;
        tx_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stx", {31'd0, stx_pad_o}, 32'd1);
        check("rst_count", {27'd0, tf_count}, 32'd0);
        check("rst_thre", {31'd0, thre}, 32'd1);
        check("rst_temt", {31'd0, temt}, 32'd1);
        check("rst_tstate", {29'd0, tstate}, 32'd0);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge clk);

        // Single frames: lcr, data, data bits, parity enable, parity bit, stop ticks
        send(8'h03, 8'h55, 8, 1'b0, 1'b0, 16);
        send(8'h1B, 8'h07, 8, 1'b1, 1'b1, 16);
        send(8'h0B, 8'h07, 8, 1'b1, 1'b0, 16);
        send(8'h2B, 8'h07, 8, 1'b1, 1'b1, 16);
        send(8'h2B, 8'h00, 8, 1'b1, 1'b1, 16);
        send(8'h3B, 8'hA5, 8, 1'b1, 1'b0, 16);
        send(8'h3B, 8'h07, 8, 1'b1, 1'b0, 16);
        send(8'h18, 8'hE1, 5, 1'b1, 1'b1, 16);
        send(8'h0A, 8'hC3, 7, 1'b1, 1'b0, 16);
        send(8'h04, 8'hE3, 5, 1'b0, 1'b0, 24);
        send(8'h07, 8'h81, 8, 1'b0, 1'b0, 32);

        // Fill past full with the tick stopped, then drain back-to-back
        lcr    = 8'h03;
        enable = 1'b0;
        for (int i = 0; i < 16; i++)
            expect_frame(8'(i), 8, 1'b0, 1'b0, 16, (i == 15) ? 2 : 1);
        for (int i = 0; i <= 16; i++)
            push_byte(8'(i));
        check("full_count", {27'd0, tf_count}, 32'd16);
        check("full_thre", {31'd0, thre}, 32'd0);
        enable = 1'b1;
        wait_done("drain16", 3500);

        // Flush and push on the same clock: flush wins
        enable = 1'b0;
        push_byte(8'hA1);
        push_byte(8'hA2);
        check("pre_flush_count", {27'd0, tf_count}, 32'd2);
        @(negedge clk);
        tx_reset = 1'b1;
        tf_push  = 1'b1;
        wb_dat_i = 8'h99;
        @(negedge clk);
        tx_reset = 1'b0;
        tf_push  = 1'b0;
        check("flush_push_count", {27'd0, tf_count}, 32'd0);
        check("flush_thre", {31'd0, thre}, 32'd1);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        check("flush_no_tx", {31'd0, temt}, 32'd1);

        // Push and pop on the same clock leave the count unchanged
        enable = 1'b0;
        expect_frame(8'h11, 8, 1'b0, 1'b0, 16, 1);
        expect_frame(8'h22, 8, 1'b0, 1'b0, 16, 1);
        expect_frame(8'h33, 8, 1'b0, 1'b0, 16, 1);
        expect_frame(8'h44, 8, 1'b0, 1'b0, 16, 2);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        @(negedge clk);
        tf_push  = 1'b1;
        wb_dat_i = 8'h44;
        enable   = 1'b1;
        @(negedge clk);
        tf_push  = 1'b0;
        check("push_pop_count", {27'd0, tf_count}, 32'd3);
        wait_done("drain4", 1000);

        // Break request mid-frame on a line held high by 0xFF data
        mon_en = 1'b0;
        lcr    = 8'h03;
        push_byte(8'hFF);
        repeat (40) @(negedge clk);
        check("pre_break_stx", {31'd0, stx_pad_o}, 32'd1);
        lcr = 8'h43;
        @(negedge clk);
`ifdef UART_TX_BREAK_EN
        check("break_stx", {31'd0, stx_pad_o}, 32'd0);
`else
        check("break_ignored_stx", {31'd0, stx_pad_o}, 32'd1);
`endif
        lcr = 8'h03;
        @(negedge clk);
        check("break_release_stx", {31'd0, stx_pad_o}, 32'd1);
        wait_done("break_frame_done", 400);

        // Asynchronous reset in the middle of a character
        push_byte(8'hAA);
        push_byte(8'hBB);
        repeat (30) @(negedge clk);
        check("busy_before_reset", {31'd0, temt}, 32'd0);
        #2 wb_rst_i = 1'b1;
        #1;
        check("async_rst_stx", {31'd0, stx_pad_o}, 32'd1);
        check("async_rst_tstate", {29'd0, tstate}, 32'd0);
        check("async_rst_count", {27'd0, tf_count}, 32'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        send(8'h03, 8'h3C, 8, 1'b0, 1'b0, 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
